// File: rtl/stack_pkg.sv
// Shared types and constants for the operand-stack sequencer.
package stack_pkg;

  // Default width of one evaluation-stack slot.
  localparam int SLOT_W = 32;

  typedef logic [SLOT_W-1:0] slot_t;

  // Sequencer states, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHECK     = 3'd1;
  localparam state_t ST_POP_REQ   = 3'd2;
  localparam state_t ST_POP_WAIT  = 3'd3;
  localparam state_t ST_PUSH_REQ  = 3'd4;
  localparam state_t ST_PUSH_WAIT = 3'd5;
  localparam state_t ST_FIN       = 3'd6;
  localparam state_t ST_FAIL      = 3'd7;

  // Error codes reported on err_code.
  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE  = 2'd0;
  localparam err_code_t ERR_UNDER = 2'd1;
  localparam err_code_t ERR_OVER  = 2'd2;
  localparam err_code_t ERR_BAD   = 2'd3;

endpackage

// File: rtl/handshake_timer.sv
// Wait-cycle counter for a trigger/done handshake; expired once TIMEOUT cycles have elapsed.
module handshake_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT));

  // Count wait cycles; saturate at the limit so expired stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Pops up to MAX_POP operands then pushes up to MAX_PUSH results per request,
// tracking stack occupancy and reporting underflow, overflow and timeout.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W   = SLOT_W,
  parameter int MAX_POP  = 4,
  parameter int MAX_PUSH = 2,
  parameter int DEPTH    = 256,
  parameter int TIMEOUT  = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_POP+1)-1:0]      pop_count,
  input  logic [$clog2(MAX_PUSH+1)-1:0]     push_count,
  input  logic [MAX_PUSH*DATA_W-1:0]        push_data,
  output logic [MAX_POP*DATA_W-1:0]         operands,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [1:0]                        err_code,
  output logic [$clog2(DEPTH+1)-1:0]        depth,
  output logic                              evalpush,
  output logic                              evaltrigger,
  output logic [DATA_W-1:0]                 evalwrite,
  input  logic [DATA_W-1:0]                 evalread,
  input  logic                              evaldone
);

  localparam int POP_W   = $clog2(MAX_POP + 1);
  localparam int PUSH_W  = $clog2(MAX_PUSH + 1);
  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int SUM_W   = DEPTH_W + 1;

  state_t                         state_q, state_d;
  logic [POP_W-1:0]               rem_q;         // pops still to do; latched pop_count in CHECK
  logic [PUSH_W-1:0]              push_total_q;
  logic [PUSH_W-1:0]              k_q;           // next push slot
  logic [DEPTH_W-1:0]             depth_q;
  logic [MAX_POP-1:0][DATA_W-1:0] operands_q;
  err_code_t                      err_code_q, fail_code;
  logic                           timer_clear, timer_en, timer_expired;
  logic [SUM_W-1:0]               after_ops;

  // Occupancy after the whole request; only meaningful once underflow is excluded.
  assign after_ops = {1'b0, depth_q} - SUM_W'(rem_q) + SUM_W'(push_total_q);

  handshake_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // Next-state selection, request validation and timer control.
  always_comb begin
    state_d     = state_q;
    fail_code   = ERR_NONE;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CHECK;
      ST_CHECK: begin
        if (rem_q > POP_W'(MAX_POP) || push_total_q > PUSH_W'(MAX_PUSH)) begin
          state_d   = ST_FAIL;
          fail_code = ERR_BAD;
        end else if (SUM_W'(rem_q) > SUM_W'(depth_q)) begin
          state_d   = ST_FAIL;
          fail_code = ERR_UNDER;
        end else if (after_ops > SUM_W'(DEPTH)) begin
          state_d   = ST_FAIL;
          fail_code = ERR_OVER;
        end else if (rem_q != '0) begin
          state_d = ST_POP_REQ;
        end else if (push_total_q != '0) begin
          state_d = ST_PUSH_REQ;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_POP_REQ: begin
        timer_clear = 1'b1;
        state_d     = ST_POP_WAIT;
      end
      ST_POP_WAIT: begin
        if (evaldone) begin
          if (rem_q > POP_W'(1))          state_d = ST_POP_REQ;
          else if (push_total_q != '0)    state_d = ST_PUSH_REQ;
          else                            state_d = ST_FIN;
        end else if (timer_expired) begin
          state_d   = ST_FAIL;
          fail_code = ERR_BAD;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_PUSH_REQ: begin
        timer_clear = 1'b1;
        state_d     = ST_PUSH_WAIT;
      end
      ST_PUSH_WAIT: begin
        if (evaldone) begin
          state_d = (k_q + 1'b1 < push_total_q) ? ST_PUSH_REQ : ST_FIN;
        end else if (timer_expired) begin
          state_d   = ST_FAIL;
          fail_code = ERR_BAD;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_FIN, ST_FAIL: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request latching, operand capture, occupancy and error-code tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q        <= '0;
      push_total_q <= '0;
      k_q          <= '0;
      depth_q      <= '0;
      operands_q   <= '0;
      err_code_q   <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_q        <= pop_count;
            push_total_q <= push_count;
            k_q          <= '0;
            err_code_q   <= ERR_NONE;
          end
        end
        ST_POP_WAIT: begin
          if (evaldone) begin
            // First pop returns the former top, which lands in the highest slot.
            for (int i = 0; i < MAX_POP; i++) begin
              if (rem_q - 1'b1 == POP_W'(i)) operands_q[i] <= evalread;
            end
            rem_q   <= rem_q - 1'b1;
            depth_q <= depth_q - 1'b1;
          end
        end
        ST_PUSH_WAIT: begin
          if (evaldone) begin
            k_q     <= k_q + 1'b1;
            depth_q <= depth_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (state_d == ST_FAIL) err_code_q <= fail_code;
    end
  end

  // Select the push slot currently being written; zero outside a push request.
  always_comb begin
    evalwrite = '0;
    if (state_q == ST_PUSH_REQ) begin
      for (int i = 0; i < MAX_PUSH; i++) begin
        if (k_q == PUSH_W'(i)) evalwrite = push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_FIN) && (state_q != ST_FAIL);
  assign done        = (state_q == ST_FIN);
  assign err         = (state_q == ST_FAIL);
  assign evaltrigger = (state_q == ST_POP_REQ) || (state_q == ST_PUSH_REQ);
  assign evalpush    = (state_q == ST_PUSH_REQ);
  assign operands    = operands_q;
  assign err_code    = err_code_q;
  assign depth       = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized scoreboard bench for stack_sequencer with a behavioural eval-stack responder.
module tb_stack_sequencer;

  localparam int DATA_W   = 32;
  localparam int MAX_POP  = 4;
  localparam int MAX_PUSH = 2;
  localparam int DEPTH    = 256;
  localparam int TIMEOUT  = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   pop_count = '0;
  logic [1:0]   push_count = '0;
  logic [63:0]  push_data = '0;
  logic [127:0] operands;
  logic         busy, done, err;
  logic [1:0]   err_code;
  logic [8:0]   depth;
  logic         evalpush, evaltrigger;
  logic [31:0]  evalwrite;
  logic [31:0]  evalread = '0;
  logic         evaldone = 1'b0;

  stack_sequencer #(
    .DATA_W  (DATA_W),
    .MAX_POP (MAX_POP),
    .MAX_PUSH(MAX_PUSH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pop_count  (pop_count),
    .push_count (push_count),
    .push_data  (push_data),
    .operands   (operands),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .depth      (depth),
    .evalpush   (evalpush),
    .evaltrigger(evaltrigger),
    .evalwrite  (evalwrite),
    .evalread   (evalread),
    .evaldone   (evaldone)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    int          dep;
    logic [127:0] ops;
  } resp_t;

  typedef struct {
    bit          push;
    logic [31:0] data;
  } traffic_t;

  resp_t       sb[$];
  traffic_t    exp_tr[$];
  logic [31:0] ref_stk[$];      // reference stack, index 0 = bottom
  logic [127:0] exp_ops = '0;
  logic [31:0] mem [0:DEPTH+7];  // responder's own storage
  int          sp = 0;
  bit          withhold = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  // mode 0: normal, 1: eval stack stalls (timeout expected), 2: aborted by reset
  task automatic issue(input int p, input int n, input logic [63:0] data, input int mode);
    resp_t r;
    r.is_err = 1'b1;
    r.code   = 2'd0;
    if (p > MAX_POP || n > MAX_PUSH) begin
      r.code = 2'd3;
    end else if (p > ref_stk.size()) begin
      r.code = 2'd1;
    end else if (ref_stk.size() - p + n > DEPTH) begin
      r.code = 2'd2;
    end else if (mode != 0) begin
      r.code = 2'd3;
      exp_tr.push_back('{push: (p == 0), data: data[31:0]});
    end else begin
      r.is_err = 1'b0;
      for (int j = 0; j < p; j++) begin
        exp_ops[j*32 +: 32] = ref_stk[ref_stk.size() - p + j];
        exp_tr.push_back('{push: 1'b0, data: 32'h0});
      end
      repeat (p) void'(ref_stk.pop_back());
      for (int k = 0; k < n; k++) begin
        ref_stk.push_back(data[k*32 +: 32]);
        exp_tr.push_back('{push: 1'b1, data: data[k*32 +: 32]});
      end
    end
    r.dep = ref_stk.size();
    r.ops = exp_ops;
    if (mode != 2) sb.push_back(r);
    pop_count  = 3'(p);
    push_count = 2'(n);
    push_data  = data;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_event("completion_timeout", "no done/err");
    @(negedge clk);
  endtask

  task automatic run(input int p, input int n, input logic [63:0] data);
    issue(p, n, data, 0);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_trig"}, 128'(evaltrigger), 128'(0));
    check({tag, "_push"}, 128'(evalpush), 128'(0));
    check({tag, "_code"}, 128'(err_code), 128'(0));
    check({tag, "_depth"}, 128'(depth), 128'(0));
    check({tag, "_ops"}, operands, 128'(0));
    check({tag, "_wr"}, 128'(evalwrite), 128'(0));
  endtask

  // Eval-stack responder: checks each trigger against expected traffic, answers after a random delay.
  initial begin
    bit          is_push;
    logic [31:0] wdata;
    int          d;
    traffic_t    t;
    forever begin
      @(negedge clk);
      evaldone = 1'b0;
      if (rst_n && evaltrigger) begin
        if (exp_tr.size() == 0) begin
          fail_event("unexpected_trigger", evalpush ? "push" : "pop");
        end else begin
          t = exp_tr.pop_front();
          check("trigger_dir", 128'(evalpush), 128'(t.push));
          if (t.push) check("evalwrite", 128'(evalwrite), 128'(t.data));
        end
        if (!withhold) begin
          is_push = evalpush;
          wdata   = evalwrite;
          d       = $urandom_range(0, 3);
          repeat (d + 1) @(negedge clk);
          if (is_push) begin
            if (sp < DEPTH + 8) mem[sp] = wdata;
            sp++;
          end else begin
            sp--;
            evalread = (sp >= 0 && sp < DEPTH + 8) ? mem[sp] : 32'hDEAD_BEEF;
          end
          evaldone = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: every done/err pulse consumes one expected response.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      resp_t r;
      check("done_err_exclusive", 128'(done && err), 128'(0));
      if (sb.size() == 0) begin
        fail_event("unexpected_completion", done ? "done" : "err");
      end else begin
        r = sb.pop_front();
        check("resp_kind", 128'(err), 128'(r.is_err));
        check("err_code", 128'(err_code), 128'(r.code));
        check("depth", 128'(depth), 128'(r.dep));
        check("operands", operands, r.ops);
      end
    end
  end

  initial begin
    int p, n, cnt;
    bit seen;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: two pushes, then pop both back.
    run(0, 2, {32'h0000_0007, 32'hFFFF_FFF9});
    run(2, 0, 64'h0);
    check("ops_deepest", 128'(operands[31:0]), 128'(32'hFFFF_FFF9));
    check("ops_top", 128'(operands[63:32]), 128'(32'h0000_0007));
    // Underflow and bad counts.
    run(1, 0, 64'h0);
    run(5, 0, 64'h0);
    run(0, 3, 64'h0);

    // Zero-count latency: done on the second cycle after start is sampled.
    issue(0, 0, 64'h0, 0);
    check("zero_busy", 128'(busy), 128'(1));
    check("zero_early_done", 128'(done), 128'(0));
    @(negedge clk);
    check("zero_done", 128'(done), 128'(1));
    @(negedge clk);

    // Start while busy is ignored.
    issue(0, 1, {32'h0, 32'h1234_5678}, 0);
    pop_count  = 3'd0;
    push_count = 2'd2;
    start      = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Random requests, occasionally with illegal counts.
    for (int i = 0; i < 60; i++) begin
      p = $urandom_range(0, MAX_POP);
      n = $urandom_range(0, MAX_PUSH);
      if ($urandom_range(0, 7) == 0) p = $urandom_range(MAX_POP + 1, 7);
      if ($urandom_range(0, 7) == 0) n = 3;
      run(p, n, {$urandom, $urandom});
    end

    // Fill to DEPTH-1, then reach exactly DEPTH, then overflow.
    while (ref_stk.size() < DEPTH - 1) begin
      n = (DEPTH - 1 - ref_stk.size() >= 2) ? 2 : 1;
      run(0, n, {$urandom, $urandom});
    end
    run(1, 2, {$urandom, $urandom});
    check("full_depth", 128'(depth), 128'(DEPTH));
    run(0, 1, {$urandom, $urandom});

    // Withheld evaldone: err after TIMEOUT+1 wait cycles.
    withhold = 1'b1;
    issue(1, 0, 64'h0, 1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (evaltrigger) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) fail_event("timeout_trigger", "no trigger");
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cnt++;
      if (err) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_latency", 128'(seen ? cnt : -1), 128'(TIMEOUT + 2));
    @(negedge clk);

    // Reset mid-pop aborts straight to reset values.
    issue(1, 0, 64'h0, 2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    exp_tr.delete();
    ref_stk.delete();
    exp_ops = '0;
    sp      = 0;
    withhold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 2, {$urandom, $urandom});
    run(2, 0, 64'h0);

    repeat (10) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    check("traffic_drained", 128'(exp_tr.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL global_watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Parametrised operand-stack sequencer: the stack pop/push engine of the fetch-execute controller, factored out and generalised. Per request it pops up to MAX_POP operands from the evaluation stack and then pushes up to MAX_PUSH results, using the eval stack's trigger/done handshake. It also tracks stack occupancy, flags underflow/overflow and detects handshake timeout. It sits between the control FSM (requester) and the evaluation stack, so wide and multi-slot ops (long/double, dup, swap) can reuse one engine.

Parameters:
DATA_W, 32, width of one stack slot
MAX_POP, 4, max operands popped per request
MAX_PUSH, 2, max results pushed per request
DEPTH, 256, eval stack capacity in slots, for occupancy tracking
TIMEOUT, 15, max cycles to wait for evaldone after a trigger

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request strobe; sampled only in IDLE
pop_count  in  $clog2(MAX_POP+1)  operands to pop
push_count  in  $clog2(MAX_PUSH+1)  results to push
push_data  in  MAX_PUSH*DATA_W  results; slot 0 pushed first; held stable by requester while busy
operands  out  MAX_POP*DATA_W  popped values; slot 0 = deepest (operand_a), slot pop_count-1 = former top of stack
busy  out  1  high from the cycle after start is accepted until done/err
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, mutually exclusive with done
err_code  out  2  0 none, 1 underflow, 2 overflow, 3 timeout/bad count; held until next start
depth  out  $clog2(DEPTH+1)  current occupancy
evalpush  out  1  1 = push, 0 = pop
evaltrigger  out  1  one-cycle request pulse to eval stack
evalwrite  out  DATA_W  push data
evalread  in  DATA_W  pop data, valid with evaldone
evaldone  in  1  one-cycle completion pulse from eval stack

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, err, evaltrigger, evalpush = 0; err_code = 0; depth = 0; operands = 0; evalwrite = 0; timer = 0.
- States: IDLE, CHECK, POP_REQ, POP_WAIT, PUSH_REQ, PUSH_WAIT, FIN, FAIL.
- IDLE: when start = 1, latch pop_count and push_count, clear err_code, go to CHECK. start in any other state is ignored.
- CHECK: latched count > MAX_POP or > MAX_PUSH -> FAIL, code 3. pop_count > depth -> FAIL, code 1. depth - pop_count + push_count > DEPTH -> FAIL, code 2. Otherwise go to POP_REQ if pop_count > 0, else PUSH_REQ if push_count > 0, else FIN. A failed check issues no stack traffic.
- POP_REQ: evaltrigger = 1 and evalpush = 0 for exactly one cycle; clear timer; go to POP_WAIT.
- POP_WAIT: on evaldone, store evalread into slot remaining-1, decrement remaining and depth, then go to POP_REQ if remaining > 0, else PUSH_REQ/FIN. Otherwise increment timer; timer = TIMEOUT -> FAIL, code 3.
- PUSH_REQ: evalwrite = push_data slot k (k counts up from 0); evaltrigger = 1 and evalpush = 1 for one cycle; go to PUSH_WAIT.
- PUSH_WAIT: on evaldone, increment depth and k, then go to PUSH_REQ or FIN. Same timeout rule as POP_WAIT.
- FIN: done = 1 for one cycle, then IDLE. FAIL: err = 1 for one cycle, then IDLE.
- Latency: zero-count request gives done 2 cycles after start is sampled. Each slot costs 2 cycles plus the eval stack response delay.
- evaldone outside a WAIT state is ignored; depth is unchanged.
- Pops always complete before pushes, so pop-then-push for the same op is ordered. Slots not popped keep their previous operands values.
- rst_n low mid-transaction aborts immediately to the reset values; no done or err pulse.

Decomposition:
- Package stack_pkg holds: the state enum, the err_code constants (ERR_NONE, ERR_UNDER, ERR_OVER, ERR_BAD), and a slot type sized by DATA_W.
- Optional sub-module handshake_timer: counter with clear/enable and a TIMEOUT compare. It is reusable by the LVA handshake.

Test Plan:
- Reset, then push_count = 2, push_data = {0x0000_0007, 0xFFFF_FFF9} -> two pushes in order slot0, slot1; done pulses once; depth = 2.
- From depth 2, pop_count = 2 -> operands slot0 = 0xFFFF_FFF9 (deepest) and slot1 = 0x0000_0007 (top); depth = 0.
- depth = 0, pop_count = 1 -> no evaltrigger; err pulses; err_code = 1.
- depth = DEPTH - 1, pop 1 and push 2 -> succeeds, depth = DEPTH. A further push of 1 -> err_code = 2.
- Stack model withholds evaldone -> err after TIMEOUT + 1 wait cycles, err_code = 3. Then drop rst_n mid-pop -> all outputs at reset values within the same cycle.
- Zero-count start -> done exactly 2 cycles later. A start pulse while busy is ignored.
